shift_seq_ctrl: RTL
===================

Name: shift_seq_ctrl

Overview:
Command-driven sequencer for the 4-bit universal shift register datapath (uni_shift_reg_v).
- Accepts one {data, op, count} command over a valid/ready handshake.
- Loads the datapath, then holds the datapath select code for exactly `count` clock cycles.
- Returns the final register value with a one-cycle done pulse.
- Sits between a command producer (bus slave or test sequencer) and the shift register; it is the only driver of the datapath's in/Sel/load.

Parameters:
DATA_W, 4, datapath width; must match the shift register.
SEL_W, 3, width of the datapath select bus.
CNT_W, 4, width of the shift count; max count 2**CNT_W-1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-low; state cleared while low.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command.
cmd_data  input  DATA_W  value to load.
cmd_op  input  SEL_W  shift operation code.
cmd_cnt  input  CNT_W  number of shift cycles.
sr_in  output  DATA_W  to datapath in.
sr_sel  output  SEL_W  to datapath Sel.
sr_load  output  1  to datapath load.
sr_result  input  DATA_W  from datapath result (registered in the datapath).
done  output  1  one-cycle pulse; res_data valid.
res_data  output  DATA_W  final register value, valid while done=1.
err  output  1  one-cycle pulse with done when cmd_op was illegal.
busy  output  1  high in every state except IDLE.

Behaviour:
- Op/select encoding (shared with the datapath):
  - 000 HOLD, 001 SHR (logical right), 010 SHL, 011 ROR, 100 ROL, 101 ASR.
  - 110 and 111 are illegal as cmd_op.
- States: IDLE, LOAD, SHIFT, DONE. Registers: op_q, data_q, rem_q (CNT_W), illegal_q.
- IDLE:
  - cmd_ready=1 (forced 0 while rst low); sr_sel=HOLD; sr_load=0.
  - On cmd_valid&&cmd_ready: capture data_q/op_q/cnt into rem_q, set illegal_q=(cmd_op>=110), go to LOAD.
- LOAD (one cycle):
  - sr_load=1, sr_in=data_q, sr_sel=HOLD.
  - Next state is DONE if rem_q==0 or illegal_q; otherwise SHIFT.
- SHIFT:
  - sr_load=0, sr_sel=op_q; rem_q decrements every cycle.
  - Go to DONE on the edge where rem_q==1. This gives exactly cmd_cnt shift edges.
- DONE (one cycle):
  - sr_sel=HOLD; done=1; res_data=sr_result; err=illegal_q; return to IDLE.
- Outputs outside these states:
  - res_data=0 when done=0; err=0 when done=0.
  - sr_in=data_q in all states; data_q resets to 0.
- Latency: handshake edge to done cycle is cmd_cnt+2 cycles (2 for cnt=0 or an illegal op). Back-to-back throughput: one command per cmd_cnt+3 cycles.
- cmd_valid while busy: ignored, cmd_ready=0. The producer must hold the command; none is dropped or queued.
- Count wrap: none. A count of 2**CNT_W-1 executes fully; rem_q never underflows.
- Reset, including mid-SHIFT:
  - State→IDLE; all registers 0.
  - Outputs: cmd_ready=0 while low, then 1; done=0, err=0, busy=0, sr_load=0, sr_sel=HOLD, sr_in=0, res_data=0.
  - The datapath contents are not cleared by this block.

Decomposition:
- Package shift_seq_pkg holds:
  - the op/select localparams (OP_HOLD..OP_ASR) and OP_ILLEGAL_MIN=3'b110;
  - the state encoding (2-bit localparams ST_IDLE/ST_LOAD/ST_SHIFT/ST_DONE).
- One natural sub-module: shift_seq_cnt, a loadable down-counter for rem_q with a `last` flag (rem_q==1) and a `zero` flag.
- The FSM stays in shift_seq_ctrl.

Test Plan:
All scenarios pair the controller with uni_shift_reg_v.
1. Reset: hold rst=0 for 2 cycles, release → cmd_ready=1, busy=0, done=0, sr_sel=000, sr_load=0.
2. data=1010, op=ROL, cnt=1:
   - sr_load=1 for exactly 1 cycle, then sr_sel=100 for 1 cycle.
   - done at handshake+3 with res_data=0101, err=0.
3. Count cases, all with data=1010:
   - op=SHR, cnt=2 → 2 SHIFT cycles, res_data=0010.
   - op=ASR, cnt=1 → res_data=1101.
   - op=SHL, cnt=0 → done at handshake+2 with res_data=1010.
4. Illegal op, data=1010, op=110, cnt=5 → no SHIFT state; done and err both high at handshake+2; res_data=1010.
5. Busy backpressure: command A (ROR, cnt=3) accepted; command B held valid throughout → cmd_ready=0 until A's done+1. B is accepted on the first IDLE cycle and completes correctly.
6. Mid-op reset: pull rst low during the 2nd SHIFT cycle of a cnt=4 command → immediately busy=0, sr_sel=000, no done. After release, a new command completes normally.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register sequencer: datapath select codes
// and the controller state encoding.
package shift_seq_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD        = 3'b000;
  localparam logic [OP_W-1:0] OP_SHR         = 3'b001;
  localparam logic [OP_W-1:0] OP_SHL         = 3'b010;
  localparam logic [OP_W-1:0] OP_ROR         = 3'b011;
  localparam logic [OP_W-1:0] OP_ROL         = 3'b100;
  localparam logic [OP_W-1:0] OP_ASR         = 3'b101;
  localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_seq_cnt.sv
// Loadable down-counter holding the remaining shift count; saturates at zero
// and flags the final shift cycle.
module shift_seq_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_dec,
  output logic             o_last,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == CNT_W'(1));
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for the universal shift register: load, hold the select
// code for cmd_cnt cycles, then return the register value with a done pulse.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [SEL_W-1:0]  cmd_op,
  input  logic [CNT_W-1:0]  cmd_cnt,
  output logic [DATA_W-1:0] sr_in,
  output logic [SEL_W-1:0]  sr_sel,
  output logic              sr_load,
  input  logic [DATA_W-1:0] sr_result,
  output logic              done,
  output logic [DATA_W-1:0] res_data,
  output logic              err,
  output logic              busy
);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_data;
  logic [SEL_W-1:0]  r_op;
  logic              r_illegal;
  logic              w_accept;
  logic              w_last;
  logic              w_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data    <= '0;
      r_op      <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_data    <= cmd_data;
      r_op      <= cmd_op;
      r_illegal <= (cmd_op >= SEL_W'(OP_ILLEGAL_MIN));
    end
  end

  shift_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst),
    .i_load (w_accept),
    .i_val  (cmd_cnt),
    .i_dec  (r_state == ST_SHIFT),
    .o_last (w_last),
    .o_zero (w_zero)
  );

  // NOTE: every signal driven here gets a default before the case statement,
  // otherwise a state that skips an assignment would infer a latch.
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    sr_sel    = SEL_W'(OP_HOLD);
    sr_load   = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // rst is read directly so ready is already low during the reset pulse.
        cmd_ready = rst;
        if (cmd_valid && rst) begin
          w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sr_load = 1'b1;
        w_next  = (w_zero || r_illegal) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        sr_sel = r_op;
        if (w_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_accept = cmd_valid && cmd_ready;
  assign sr_in    = r_data;
  assign busy     = (r_state != ST_IDLE);
  assign res_data = done ? sr_result : '0;
  assign err      = done && r_illegal;

endmodule
